// File: rtl/broadcast_if.sv
// Handshake bundle for the broadcast fan-out stage: one producer-side word port
// and N consumer lanes that share a single data bus.
interface broadcast_if #(
    parameter int N = 2,
    parameter int W = 16
);
    logic         arg_stb;
    logic [W-1:0] arg_dat;
    logic [N-1:0] arg_msk;
    logic         arg_rdy;
    logic [N-1:0] res_stb;
    logic [W-1:0] res_dat;
    logic [N-1:0] res_rdy;

    // The master is the environment: it produces words and consumes the lanes.
    modport master (
        output arg_stb, arg_dat, arg_msk, res_rdy,
        input  arg_rdy, res_stb, res_dat
    );

    modport slave (
        input  arg_stb, arg_dat, arg_msk, res_rdy,
        output arg_rdy, res_stb, res_dat
    );
endinterface

// File: rtl/broadcast.sv
// One-to-N fan-out: holds an accepted word until every lane in its mask has
// taken it, then frees itself for the next word.
module broadcast #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic      clk,
    input  logic      rst,
    broadcast_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] pend;
    logic [W-1:0] data;
    logic         done;
    logic         accept;

    // done looks ahead at this edge's handshakes so a new word can follow with no bubble.
    assign done   = ((pend & ~bus.res_rdy) == '0);
    assign bus.arg_rdy = (state == IDLE) | ((state == BUSY) & done);
    assign accept = bus.arg_stb & bus.arg_rdy;

    assign bus.res_stb = pend;
    assign bus.res_dat = data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pend  <= '0;
            data  <= '0;
        end else if (accept) begin
            data  <= bus.arg_dat;
            pend  <= bus.arg_msk;
            state <= (bus.arg_msk != '0) ? BUSY : IDLE;
        end else begin
            pend <= pend & ~bus.res_rdy;
            if ((state == BUSY) && done) begin
                state <= IDLE;
            end
        end
    end
endmodule
